// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 16-bit down-counting timer answering CPU accesses with a busy/ready handshake.
// Optional capture unit is built when TIMER_CAPTURE_EN is defined.
module bus_timer #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [15:0] RST_RELOAD  = 16'hFFFF
) (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [2:0]  addr,
  input  logic [15:0] data_in,
  input  logic        ram_read,
  input  logic        ram_write,
  output logic [15:0] data_out,
  output logic        busy,
  output logic        ready,
  input  logic        capture_in,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES - 1);

  state_t      state, state_nx;
  logic [2:0]  wait_cnt;
  logic [2:0]  addr_q;
  logic [15:0] data_q;
  logic        wr_q;
  logic        req, wait_done, commit;
  logic [15:0] rd_val;

  logic        en, irq_en, auto_rl, pend;
  logic [15:0] presc, reload, count, presc_cnt;
  logic        tick, expire;

`ifdef TIMER_CAPTURE_EN
  logic        cap_prev, cap_flag, cap_evt;
  logic [15:0] capture;
  assign cap_evt = capture_in & ~cap_prev;
`else
  logic        unused_capture;
  assign unused_capture = capture_in;
`endif

  assign req       = sel & (ram_read | ram_write);
  assign wait_done = (wait_cnt == WAIT_LAST);
  assign commit    = (state == S_WAIT) && wait_done && wr_q;
  assign busy      = (state == S_WAIT);
  assign ready     = (state == S_DONE);
  // >= keeps the prescaler from running the full 16-bit range when PRESC is lowered mid-count
  assign tick      = en && (presc_cnt >= presc);
  assign expire    = tick && (count == '0);

  always_ff @(posedge cpu_clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (req)       state_nx = S_WAIT;
      S_WAIT:  if (wait_done) state_nx = S_DONE;
      S_DONE:  if (!req)      state_nx = S_IDLE;
      default:                state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      wait_cnt <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      data_out <= '0;
    end else begin
      if (state == S_IDLE && req) begin
        addr_q   <= addr;
        data_q   <= data_in;
        wr_q     <= ram_write;
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 3'd1;
      end
      if (state == S_WAIT && wait_done) data_out <= wr_q ? '0 : rd_val;
      else if (state_nx != S_DONE)      data_out <= '0;
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr_q)
      3'd0:    rd_val = {13'd0, auto_rl, irq_en, en};
      3'd1:    rd_val = presc;
      3'd2:    rd_val = reload;
      3'd3:    rd_val = count;
`ifdef TIMER_CAPTURE_EN
      3'd4:    rd_val = {14'd0, cap_flag, pend};
      3'd5:    rd_val = capture;
`else
      3'd4:    rd_val = {15'd0, pend};
`endif
      default: rd_val = '0;
    endcase
  end

  // Timer update first, CPU write after it, PEND set last: encodes write-wins and set-wins priorities
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      en        <= 1'b0;
      irq_en    <= 1'b0;
      auto_rl   <= 1'b0;
      presc     <= '0;
      reload    <= RST_RELOAD;
      count     <= '0;
      presc_cnt <= '0;
      pend      <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (tick) begin
        presc_cnt <= '0;
        if (count != '0)  count <= count - 16'd1;
        else if (auto_rl) count <= reload;
        else              en    <= 1'b0;
      end else if (en) begin
        presc_cnt <= presc_cnt + 16'd1;
      end
      if (commit) begin
        case (addr_q)
          3'd0: begin
            en      <= data_q[0];
            irq_en  <= data_q[1];
            auto_rl <= data_q[2];
            if (data_q[0] && !en) presc_cnt <= '0;
          end
          3'd1:    presc  <= data_q;
          3'd2:    reload <= data_q;
          3'd3:    count  <= data_q;
          3'd4:    if (data_q[0]) pend <= 1'b0;
          default: ;
        endcase
      end
      if (expire) pend <= 1'b1;
      irq <= pend & irq_en;
    end
  end

`ifdef TIMER_CAPTURE_EN
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      cap_prev <= 1'b0;
      cap_flag <= 1'b0;
      capture  <= '0;
    end else begin
      cap_prev <= capture_in;
      if (commit && addr_q == 3'd4 && data_q[1]) cap_flag <= 1'b0;
      if (cap_evt) begin
        capture  <= count;
        cap_flag <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: scoreboard of expected read data, cycle-exact timer checks.
// Capture checks follow TIMER_CAPTURE_EN.
module tb_bus_timer;

  logic        cpu_clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [2:0]  addr = '0;
  logic [15:0] data_in = '0;
  logic        ram_read = 1'b0;
  logic        ram_write = 1'b0;
  logic [15:0] data_out;
  logic        busy, ready;
  logic        capture_in = 1'b0;
  logic        irq;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  bus_timer #(.WAIT_STATES(1), .RST_RELOAD(16'hFFFF)) dut (
    .cpu_clk(cpu_clk), .rst(rst), .sel(sel), .addr(addr), .data_in(data_in),
    .ram_read(ram_read), .ram_write(ram_write), .data_out(data_out),
    .busy(busy), .ready(ready), .capture_in(capture_in), .irq(irq)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Starts #1 after a posedge E_k; data is sampled at E_k+2; returns #1 after E_k+3.
  task automatic xfer(input bit wr, input logic [2:0] a, input logic [15:0] d, input string tag);
    int unsigned n;
    logic [15:0] e;
    string t;
    sel = 1'b1; addr = a; data_in = d; ram_write = wr; ram_read = !wr;
    if (!wr) begin
      exp_q.push_back(d);
      tag_q.push_back(tag);
    end
    @(posedge cpu_clk);
    n = 0;
    do begin
      @(negedge cpu_clk);
      n++;
    end while (!ready && n < 16);
    if (!ready) check({tag, "_timeout"}, 16'd0, 16'd1);
    if (!wr) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, data_out, e);
    end
    sel = 1'b0; ram_read = 1'b0; ram_write = 1'b0;
    @(posedge cpu_clk); #1;
    check({tag, "_rdy_drop"}, {15'd0, ready}, 16'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    xfer(1'b1, a, d, "wr");
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] e, input string tag);
    xfer(1'b0, a, e, tag);
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e;
    cyc(3);
    rst = 1'b0;
    // reset state
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_ready", {15'd0, ready}, 16'd0);
    check("rst_irq", {15'd0, irq}, 16'd0);
    check("rst_data", data_out, 16'd0);
    rd(3'd0, 16'h0000, "rst_ctrl");
    rd(3'd1, 16'h0000, "rst_presc");
    rd(3'd2, 16'hFFFF, "rst_reload");
    rd(3'd3, 16'h0000, "rst_count");
    rd(3'd4, 16'h0000, "rst_status");
    rd(3'd5, 16'h0000, "rst_cap");
    rd(3'd6, 16'h0000, "unmap6");
    rd(3'd7, 16'h0000, "unmap7");
    wr(3'd6, 16'hBEEF);
    rd(3'd6, 16'h0000, "unmap6_wr");

    // reset mid-access discards the write
    sel = 1'b1; addr = 3'd2; data_in = 16'h1234; ram_write = 1'b1;
    cyc(1);
    check("mid_busy", {15'd0, busy}, 16'd1);
    rst = 1'b1; sel = 1'b0; ram_write = 1'b0;
    cyc(1);
    check("mid_rst_busy", {15'd0, busy}, 16'd0);
    check("mid_rst_ready", {15'd0, ready}, 16'd0);
    rst = 1'b0;
    rd(3'd2, 16'hFFFF, "mid_reload");

    // handshake detail, read and write asserted together counts as write
    sel = 1'b1; addr = 3'd2; ram_read = 1'b1;
    exp_q.push_back(16'hFFFF);
    cyc(1);
    check("hs_busy1", {14'd0, busy, ready}, 16'b10);
    cyc(1);
    check("hs_ready2", {14'd0, busy, ready}, 16'b01);
    e = exp_q.pop_front();
    check("hs_data", data_out, e);
    cyc(3);
    check("hs_hold", {15'd0, ready}, 16'd1);
    check("hs_hold_data", data_out, 16'hFFFF);
    sel = 1'b0; ram_read = 1'b0;
    cyc(1);
    check("hs_drop", {15'd0, ready}, 16'd0);
    check("hs_drop_data", data_out, 16'd0);
    sel = 1'b1; addr = 3'd1; data_in = 16'h0055; ram_read = 1'b1; ram_write = 1'b1;
    cyc(3);
    sel = 1'b0; ram_read = 1'b0; ram_write = 1'b0;
    cyc(1);
    rd(3'd1, 16'h0055, "rw_both");

    // periodic auto-reload: EN edge E0 is the CTRL commit, task returns after E1
    wr(3'd1, 16'd3);
    wr(3'd2, 16'd2);
    wr(3'd3, 16'd2);
    wr(3'd0, 16'd7);
    cyc(11);
    check("t3_irq_e12", {15'd0, irq}, 16'd0);
    cyc(1);
    check("t3_irq_e13", {15'd0, irq}, 16'd1);
    rd(3'd3, 16'd2, "t3_count_reload");
    rd(3'd4, 16'd1, "t3_pend");
    wr(3'd4, 16'd1);
    check("t3_irq_clr", {15'd0, irq}, 16'd0);
    cyc(2);
    check("t3_irq_e24", {15'd0, irq}, 16'd0);
    cyc(1);
    check("t3_irq_e25", {15'd0, irq}, 16'd1);
    wr(3'd0, 16'd0);

    // one-shot expiry
    wr(3'd1, 16'd0);
    wr(3'd3, 16'd1);
    wr(3'd4, 16'd1);
    wr(3'd0, 16'd3);
    check("t4_irq_e1", {15'd0, irq}, 16'd0);
    cyc(1);
    check("t4_irq_e2", {15'd0, irq}, 16'd0);
    cyc(1);
    check("t4_irq_e3", {15'd0, irq}, 16'd1);
    rd(3'd0, 16'd2, "t4_ctrl_en_off");
    rd(3'd3, 16'd0, "t4_count_zero");
    rd(3'd4, 16'd1, "t4_pend");
    check("t4_irq_held", {15'd0, irq}, 16'd1);
    wr(3'd4, 16'd1);
    check("t4_irq_drop", {15'd0, irq}, 16'd0);

    // COUNT write on a tick cycle wins
    wr(3'd1, 16'd3);
    wr(3'd3, 16'd100);
    wr(3'd0, 16'd1);
    cyc(1);
    wr(3'd3, 16'd5);
    rd(3'd3, 16'd5, "t5_count_wr_tick");
    wr(3'd0, 16'd0);

    // CTRL write on an expiry cycle: CPU EN wins
    wr(3'd3, 16'd0);
    wr(3'd0, 16'd1);
    cyc(1);
    wr(3'd0, 16'd1);
    rd(3'd0, 16'd1, "t5_ctrl_expiry");
    wr(3'd0, 16'd0);
    wr(3'd4, 16'd1);

    // W1C on an expiry cycle: set wins
    wr(3'd2, 16'd0);
    wr(3'd3, 16'd0);
    wr(3'd0, 16'd5);
    cyc(5);
    wr(3'd4, 16'd1);
    rd(3'd4, 16'd1, "t5_pend_w1c_expiry");
    wr(3'd0, 16'd0);
    wr(3'd4, 16'd3);
    rd(3'd4, 16'd0, "t5_status_clear");

    // capture
    wr(3'd1, 16'd0);
    wr(3'd3, 16'h0040);
    wr(3'd0, 16'd1);
    capture_in = 1'b1;
    cyc(1);
    capture_in = 1'b0;
    wr(3'd0, 16'd0);
`ifdef TIMER_CAPTURE_EN
    rd(3'd5, 16'h003F, "t6_capture");
    rd(3'd4, 16'd2, "t6_status_cap");
    wr(3'd4, 16'd2);
    rd(3'd4, 16'd0, "t6_cap_w1c");
`else
    rd(3'd5, 16'h0000, "t6_capture_off");
    rd(3'd4, 16'd0, "t6_status_off");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
